// File: rtl/iccm_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : iccm_boot_loader
// Purpose  : Receives a framed binary image from a UART byte stream and writes
//            it word-by-word into the ICCM. The core is held in reset while a
//            frame is loading and is released only after a good checksum.
//
//            Frame: MAGIC, LEN_LO, LEN_HI, LEN little-endian words, CSUM
//            (CSUM = XOR of all data bytes).
//
// Ports    : clk_i        system clock
//            rst_ni       asynchronous active-low reset
//            rx_valid_i   one-cycle strobe, rx_byte_i valid
//            rx_byte_i    received UART byte
//            we_o         ICCM write strobe, one cycle per word
//            addr_o       ICCM word address (held between writes)
//            wdata_o      ICCM write data (held between writes)
//            busy_o       frame in progress
//            core_rst_no  core reset request, active low
//            done_o       last frame loaded with good checksum (sticky)
//            err_o        last frame failed (sticky)
//
// Revision : 1.0 - initial release
// ============================================================================
module iccm_boot_loader #(
    parameter int unsigned        ADDR_W     = 12,
    parameter int unsigned        DATA_W     = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
    parameter logic [7:0]         MAGIC      = 8'hA5,
    parameter int unsigned        TIMEOUT_CY = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_byte_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              busy_o,
    output logic              core_rst_no,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned c_LANES     = DATA_W / 8;
    localparam int unsigned c_BC_W      = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam int unsigned c_TMO_W     = $clog2(TIMEOUT_CY + 1);
    localparam logic [32:0] c_MAX_WORDS = 33'd1 << ADDR_W;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LEN_LO = 3'd1;
    localparam logic [2:0] c_ST_LEN_HI = 3'd2;
    localparam logic [2:0] c_ST_DATA   = 3'd3;
    localparam logic [2:0] c_ST_CSUM   = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;
    localparam logic [2:0] c_ST_ERR    = 3'd6;

    logic [2:0]        r_state,      w_state_nxt;
    logic [7:0]        r_len_lo,     w_len_lo_nxt;
    logic [15:0]       r_len,        w_len_nxt;
    logic [c_BC_W-1:0] r_byte_cnt,   w_byte_cnt_nxt;
    logic [15:0]       r_word_idx,   w_word_idx_nxt;
    logic [DATA_W-1:0] r_buf,        w_buf_nxt;
    logic [7:0]        r_csum,       w_csum_nxt;
    logic [c_TMO_W-1:0] r_tmo,       w_tmo_nxt;
    logic              r_we,         w_we_nxt;
    logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
    logic [DATA_W-1:0] r_wdata,      w_wdata_nxt;
    logic              r_done,       w_done_nxt;
    logic              r_err,        w_err_nxt;
    logic              r_core_rst_n, w_core_rst_n_nxt;

    logic [15:0]       w_len_rx;
    logic              w_in_frame;
    logic              w_timeout;
    logic              w_last_lane;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath / output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len_lo     <= '0;
            r_len        <= '0;
            r_byte_cnt   <= '0;
            r_word_idx   <= '0;
            r_buf        <= '0;
            r_csum       <= '0;
            r_tmo        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b1;
        end else begin
            r_len_lo     <= w_len_lo_nxt;
            r_len        <= w_len_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_word_idx   <= w_word_idx_nxt;
            r_buf        <= w_buf_nxt;
            r_csum       <= w_csum_nxt;
            r_tmo        <= w_tmo_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_core_rst_n <= w_core_rst_n_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_len_lo_nxt     = r_len_lo;
        w_len_nxt        = r_len;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_word_idx_nxt   = r_word_idx;
        w_buf_nxt        = r_buf;
        w_csum_nxt       = r_csum;
        w_tmo_nxt        = r_tmo;
        w_we_nxt         = 1'b0;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_done_nxt       = r_done;
        w_err_nxt        = r_err;
        w_core_rst_n_nxt = r_core_rst_n;
        w_timeout        = 1'b0;

        w_len_rx    = {rx_byte_i, r_len_lo};
        w_last_lane = (r_byte_cnt == c_BC_W'(c_LANES - 1));
        w_in_frame  = (r_state == c_ST_LEN_LO) || (r_state == c_ST_LEN_HI) ||
                      (r_state == c_ST_DATA)   || (r_state == c_ST_CSUM);

        // Inter-byte timeout. It only counts idle cycles, so a byte arriving
        // in the cycle the limit would be hit always takes precedence.
        if (w_in_frame) begin
            if (rx_valid_i) begin
                w_tmo_nxt = '0;
            end else if (r_tmo == c_TMO_W'(TIMEOUT_CY - 1)) begin
                w_timeout = 1'b1;
                w_tmo_nxt = '0;
            end else begin
                w_tmo_nxt = r_tmo + 1'b1;
            end
        end

        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERR: begin
                if (rx_valid_i && (rx_byte_i == MAGIC)) begin
                    w_state_nxt      = c_ST_LEN_LO;
                    w_done_nxt       = 1'b0;
                    w_err_nxt        = 1'b0;
                    w_core_rst_n_nxt = 1'b0;
                    w_csum_nxt       = '0;
                    w_byte_cnt_nxt   = '0;
                    w_word_idx_nxt   = '0;
                    w_tmo_nxt        = '0;
                end
            end
            c_ST_LEN_LO: begin
                if (rx_valid_i) begin
                    w_len_lo_nxt = rx_byte_i;
                    w_state_nxt  = c_ST_LEN_HI;
                end
            end
            c_ST_LEN_HI: begin
                if (rx_valid_i) begin
                    w_len_nxt = w_len_rx;
                    if (w_len_rx == 16'd0) begin
                        w_state_nxt = c_ST_CSUM;
                    end else if ({17'd0, w_len_rx} > c_MAX_WORDS) begin
                        // Image would not fit; reject before touching the ICCM.
                        w_state_nxt = c_ST_ERR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_DATA;
                    end
                end
            end
            c_ST_DATA: begin
                if (rx_valid_i) begin
                    w_buf_nxt[{r_byte_cnt, 3'b000} +: 8] = rx_byte_i;
                    w_csum_nxt = r_csum ^ rx_byte_i;
                    if (w_last_lane) begin
                        w_we_nxt       = 1'b1;
                        w_addr_nxt     = BASE_ADDR + ADDR_W'(r_word_idx);
                        w_wdata_nxt    = w_buf_nxt;
                        w_byte_cnt_nxt = '0;
                        w_word_idx_nxt = r_word_idx + 16'd1;
                        if ((r_word_idx + 16'd1) == r_len) begin
                            w_state_nxt = c_ST_CSUM;
                        end
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    end
                end
            end
            c_ST_CSUM: begin
                if (rx_valid_i) begin
                    if (rx_byte_i == r_csum) begin
                        w_state_nxt      = c_ST_DONE;
                        w_done_nxt       = 1'b1;
                        w_core_rst_n_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_ERR;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Timeout only fires on a cycle with no byte, so it never competes
        // with a byte-driven transition above.
        if (w_timeout) begin
            w_state_nxt = c_ST_ERR;
            w_err_nxt   = 1'b1;
        end
    end

    assign we_o        = r_we;
    assign addr_o      = r_addr;
    assign wdata_o     = r_wdata;
    assign busy_o      = w_in_frame;
    assign core_rst_no = r_core_rst_n;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_iccm_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_iccm_boot_loader
// Purpose  : Self-checking bench for iccm_boot_loader. Instance A uses the
//            default geometry (12-bit address, 32-bit words); instance B uses
//            a 4-bit address space based at 14 with 16-bit words to exercise
//            address wrap and length rejection. Expected ICCM writes are
//            queued by the stimulus and consumed by per-instance monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iccm_boot_loader;

    localparam int unsigned c_TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        rx_valid_a, rx_valid_b;
    logic [7:0]  rx_byte_a,  rx_byte_b;

    logic        we_a, busy_a, crst_a, done_a, err_a;
    logic [11:0] addr_a;
    logic [31:0] wdata_a;
    logic        we_b, busy_b, crst_b, done_b, err_b;
    logic [3:0]  addr_b;
    logic [15:0] wdata_b;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_addr_a[$], exp_data_a[$];
    logic [63:0] exp_addr_b[$], exp_data_b[$];
    logic [7:0]  frame[$];

    always #5 clk = ~clk;

    iccm_boot_loader #(
        .ADDR_W(12), .DATA_W(32), .BASE_ADDR(12'd0), .MAGIC(8'hA5), .TIMEOUT_CY(c_TMO)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .rx_valid_i(rx_valid_a), .rx_byte_i(rx_byte_a),
        .we_o(we_a), .addr_o(addr_a), .wdata_o(wdata_a), .busy_o(busy_a),
        .core_rst_no(crst_a), .done_o(done_a), .err_o(err_a)
    );

    iccm_boot_loader #(
        .ADDR_W(4), .DATA_W(16), .BASE_ADDR(4'd14), .MAGIC(8'hA5), .TIMEOUT_CY(c_TMO)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .rx_valid_i(rx_valid_b), .rx_byte_i(rx_byte_b),
        .we_o(we_b), .addr_o(addr_b), .wdata_o(wdata_b), .busy_o(busy_b),
        .core_rst_no(crst_b), .done_o(done_b), .err_o(err_b)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Drives the contents of 'frame' on consecutive cycles (no gaps).
    task automatic send(input bit to_b);
        foreach (frame[i]) begin
            @(negedge clk);
            if (to_b) begin
                rx_valid_b = 1'b1;
                rx_byte_b  = frame[i];
            end else begin
                rx_valid_a = 1'b1;
                rx_byte_a  = frame[i];
            end
        end
        @(negedge clk);
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
    endtask

    task automatic expect_a(input logic [63:0] a, input logic [63:0] d);
        exp_addr_a.push_back(a);
        exp_data_a.push_back(d);
    endtask

    task automatic expect_b(input logic [63:0] a, input logic [63:0] d);
        exp_addr_b.push_back(a);
        exp_data_b.push_back(d);
    endtask

    // Write monitors: every we pulse must match the next queued write.
    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            if (exp_addr_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_a_unexpected: got write addr=%0h data=%0h, expected no write", addr_a, wdata_a);
            end else begin
                chk("wr_a_addr", 64'(addr_a), exp_addr_a.pop_front());
                chk("wr_a_data", 64'(wdata_a), exp_data_a.pop_front());
            end
        end
        if (we_b === 1'b1) begin
            if (exp_addr_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_b_unexpected: got write addr=%0h data=%0h, expected no write", addr_b, wdata_b);
            end else begin
                chk("wr_b_addr", 64'(addr_b), exp_addr_b.pop_front());
                chk("wr_b_data", 64'(wdata_b), exp_data_b.pop_front());
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        rx_byte_a  = 8'h00;
        rx_byte_b  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_we",    64'(we_a),    64'd0);
        chk("rst_busy",  64'(busy_a),  64'd0);
        chk("rst_done",  64'(done_a),  64'd0);
        chk("rst_err",   64'(err_a),   64'd0);
        chk("rst_crst",  64'(crst_a),  64'd1);
        chk("rst_addr",  64'(addr_a),  64'd0);
        chk("rst_wdata", 64'(wdata_a), 64'd0);
        chk("rst_crst_b", 64'(crst_b), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: two words, checksum 78^56^34^12^EF^BE^AD^DE = 0x2A
        expect_a(64'd0, 64'h12345678);
        expect_a(64'd1, 64'hDEADBEEF);
        frame = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        send(1'b0);
        repeat (2) @(negedge clk);
        chk("t1_done", 64'(done_a), 64'd1);
        chk("t1_err",  64'(err_a),  64'd0);
        chk("t1_crst", 64'(crst_a), 64'd1);
        chk("t1_busy", 64'(busy_a), 64'd0);

        // T2: same frame, wrong checksum; writes still happen
        expect_a(64'd0, 64'h12345678);
        expect_a(64'd1, 64'hDEADBEEF);
        frame[11] = 8'h2B;
        send(1'b0);
        repeat (2) @(negedge clk);
        chk("t2_err",  64'(err_a),  64'd1);
        chk("t2_done", 64'(done_a), 64'd0);
        chk("t2_crst", 64'(crst_a), 64'd0);

        // T3: partial word then silence -> timeout after c_TMO idle cycles
        frame = {8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
        send(1'b0);
        repeat (c_TMO - 2) @(negedge clk);
        chk("t3_err_early",  64'(err_a),  64'd0);
        chk("t3_busy_early", 64'(busy_a), 64'd1);
        chk("t3_crst_hold",  64'(crst_a), 64'd0);
        repeat (3) @(negedge clk);
        chk("t3_err",  64'(err_a),  64'd1);
        chk("t3_busy", 64'(busy_a), 64'd0);

        // T3b: byte arriving on the would-be timeout cycle wins; then good frame
        expect_a(64'd0, 64'h44332211);
        frame = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send(1'b0);
        repeat (c_TMO - 2) @(negedge clk);
        frame = {8'h33, 8'h44, 8'h44};
        send(1'b0);
        repeat (2) @(negedge clk);
        chk("t3b_done", 64'(done_a), 64'd1);
        chk("t3b_err",  64'(err_a),  64'd0);
        chk("t3b_crst", 64'(crst_a), 64'd1);

        // T4: 16-bit words at base 14 in a 16-word space wrap to address 0
        expect_b(64'd14, 64'h0201);
        expect_b(64'd15, 64'h0403);
        expect_b(64'd0,  64'h0605);
        frame = {8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        send(1'b1);
        repeat (2) @(negedge clk);
        chk("t4_done", 64'(done_b), 64'd1);
        chk("t4_crst", 64'(crst_b), 64'd1);

        // LEN=17 exceeds 16 words: rejected straight after LEN_HI
        frame = {8'hA5, 8'h11, 8'h00};
        send(1'b1);
        chk("t4_len17_err",  64'(err_b),  64'd1);
        chk("t4_len17_busy", 64'(busy_b), 64'd0);
        chk("t4_len17_done", 64'(done_b), 64'd0);
        chk("t4_len17_crst", 64'(crst_b), 64'd0);

        // LEN=16 is the largest accepted length
        frame = {8'hA5, 8'h10, 8'h00};
        send(1'b1);
        chk("t4_len16_busy", 64'(busy_b), 64'd1);
        chk("t4_len16_err",  64'(err_b),  64'd0);
        repeat (c_TMO + 4) @(negedge clk);
        chk("t4_len16_tmo",  64'(err_b),  64'd1);

        // T5: zero-length image
        frame = {8'hA5, 8'h00, 8'h00, 8'h00};
        send(1'b0);
        repeat (2) @(negedge clk);
        chk("t5_done", 64'(done_a), 64'd1);
        chk("t5_err",  64'(err_a),  64'd0);
        chk("t5_crst", 64'(crst_a), 64'd1);

        // T6: asynchronous reset in the middle of DATA
        frame = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56};
        send(1'b0);
        chk("t6_busy_pre", 64'(busy_a), 64'd1);
        chk("t6_crst_pre", 64'(crst_a), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_we",   64'(we_a),   64'd0);
        chk("t6_busy", 64'(busy_a), 64'd0);
        chk("t6_done", 64'(done_a), 64'd0);
        chk("t6_err",  64'(err_a),  64'd0);
        chk("t6_crst", 64'(crst_a), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        // Remainder of the aborted frame plus a stray byte must all be ignored
        frame = {8'h34, 8'h12, 8'h11};
        send(1'b0);
        repeat (2) @(negedge clk);
        chk("t6_busy_post", 64'(busy_a), 64'd0);
        chk("t6_crst_post", 64'(crst_a), 64'd1);
        chk("t6_done_post", 64'(done_a), 64'd0);

        repeat (3) @(negedge clk);
        chk("pending_wr_a", 64'(exp_addr_a.size()), 64'd0);
        chk("pending_wr_b", 64'(exp_addr_b.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
